// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - rename-stage / free-list handshake bundle (fl_err present under FREELIST_ERR_CHK_EN)
interface phys_reg_free_list_if #(
  parameter int PHYS_COUNT    = 16,
  parameter int ARCH_COUNT    = 8,
  parameter int ALLOC_PORTS   = 4,
  parameter int RECLAIM_PORTS = 4,
  parameter int ADDR_WIDTH    = $clog2(PHYS_COUNT),
  parameter int FL_DEPTH      = PHYS_COUNT - ARCH_COUNT,
  parameter int CMT_W         = $clog2(ALLOC_PORTS + 1),
  parameter int CNT_W         = $clog2(FL_DEPTH + 1)
);
  logic                     clk_en;
  logic [ALLOC_PORTS-1:0]   alloc_req;
  logic [ALLOC_PORTS-1:0]   alloc_gnt;
  logic [ADDR_WIDTH-1:0]    alloc_addr [ALLOC_PORTS];
  logic [RECLAIM_PORTS-1:0] reclaim_en;
  logic [ADDR_WIDTH-1:0]    reclaim_addr [RECLAIM_PORTS];
  logic [CMT_W-1:0]         commit_cnt;
  logic                     flush;
  logic [CNT_W-1:0]         free_count;
  logic                     fl_empty;
`ifdef FREELIST_ERR_CHK_EN
  logic                     fl_err;
`endif

  modport master (
    output clk_en, alloc_req, reclaim_en, reclaim_addr, commit_cnt, flush,
`ifdef FREELIST_ERR_CHK_EN
    input  fl_err,
`endif
    input  alloc_gnt, alloc_addr, free_count, fl_empty
  );

  modport slave (
    input  clk_en, alloc_req, reclaim_en, reclaim_addr, commit_cnt, flush,
`ifdef FREELIST_ERR_CHK_EN
    output fl_err,
`endif
    output alloc_gnt, alloc_addr, free_count, fl_empty
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular physical register free list with speculative/committed heads (checks under FREELIST_ERR_CHK_EN)
module phys_reg_free_list #(
  parameter int PHYS_COUNT    = 16,
  parameter int ARCH_COUNT    = 8,
  parameter int ALLOC_PORTS   = 4,
  parameter int RECLAIM_PORTS = 4,
  parameter int ADDR_WIDTH    = $clog2(PHYS_COUNT),
  parameter int FL_DEPTH      = PHYS_COUNT - ARCH_COUNT
) (
  input  logic                clk,
  input  logic                async_rst_n,
  phys_reg_free_list_if.slave bus
);
  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CNT_W = $clog2(FL_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] r_entries [FL_DEPTH];
  logic [PTR_W-1:0]      r_spec_head;
  logic [PTR_W-1:0]      r_cmt_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_free_count;
  // speculative allocations not yet committed; resolves the head==tail ambiguity on flush
  logic [CNT_W-1:0]      r_spec_cnt;

  logic [ALLOC_PORTS-1:0]   w_gnt;
  logic [ADDR_WIDTH-1:0]    w_addr [ALLOC_PORTS];
  int                       w_n_gnt;
  logic [RECLAIM_PORTS-1:0] w_push_en;
  logic [PTR_W-1:0]         w_push_ptr [RECLAIM_PORTS];
  int                       w_n_push;
  logic                     w_drop;
  logic [PTR_W-1:0]         w_spec_head_nx;
  logic [PTR_W-1:0]         w_cmt_head_nx;
  logic [PTR_W-1:0]         w_tail_nx;
  logic [CNT_W-1:0]         w_free_nx;
  logic [CNT_W-1:0]         w_spec_cnt_nx;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int off);
    ptr_add = PTR_W'((int'(base) + off) % FL_DEPTH);
  endfunction

  // rank requesting ports in order and hand each the next free entry while entries remain
  always_comb begin
    int rank;
    rank  = 0;
    w_gnt = '0;
    for (int p = 0; p < ALLOC_PORTS; p++) begin
      w_addr[p] = '0;
      if (bus.clk_en && !bus.flush && bus.alloc_req[p] && (rank < int'(r_free_count))) begin
        w_gnt[p]  = 1'b1;
        w_addr[p] = r_entries[ptr_add(r_spec_head, rank)];
        rank      = rank + 1;
      end
    end
    w_n_gnt = rank;
  end

  assign bus.alloc_gnt  = w_gnt;
  assign bus.alloc_addr = w_addr;
  assign bus.free_count = r_free_count;
  assign bus.fl_empty   = (r_free_count == '0);

  // pack accepted reclaims at tail in port order; a push past FL_DEPTH free entries is dropped
  always_comb begin
    int acc;
    acc    = 0;
    w_drop = 1'b0;
    for (int q = 0; q < RECLAIM_PORTS; q++) begin
      w_push_en[q]  = 1'b0;
      w_push_ptr[q] = ptr_add(r_tail, acc);
      if (bus.clk_en && bus.reclaim_en[q]) begin
        if ((int'(r_free_count) + acc) < FL_DEPTH) begin
          w_push_en[q] = 1'b1;
          acc          = acc + 1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    w_n_push = acc;
  end

  // pointer and counter updates; flush rewinds the speculative head to the post-commit head
  always_comb begin
    int f_tmp;
    int s_tmp;
    w_spec_head_nx = r_spec_head;
    w_cmt_head_nx  = r_cmt_head;
    w_tail_nx      = r_tail;
    w_free_nx      = r_free_count;
    w_spec_cnt_nx  = r_spec_cnt;
    f_tmp          = int'(r_free_count);
    s_tmp          = int'(r_spec_cnt);
    if (bus.clk_en) begin
      w_cmt_head_nx = ptr_add(r_cmt_head, int'(bus.commit_cnt));
      w_tail_nx     = ptr_add(r_tail, w_n_push);
      if (bus.flush) begin
        w_spec_head_nx = w_cmt_head_nx;
        f_tmp = int'(r_free_count) + w_n_push + int'(r_spec_cnt) - int'(bus.commit_cnt);
        s_tmp = 0;
      end else begin
        w_spec_head_nx = ptr_add(r_spec_head, w_n_gnt);
        f_tmp = int'(r_free_count) + w_n_push - w_n_gnt;
        s_tmp = int'(r_spec_cnt) + w_n_gnt - int'(bus.commit_cnt);
      end
      if (f_tmp > FL_DEPTH) f_tmp = FL_DEPTH;
      if (f_tmp < 0) f_tmp = 0;
      if (s_tmp > FL_DEPTH) s_tmp = FL_DEPTH;
      if (s_tmp < 0) s_tmp = 0;
      w_free_nx     = CNT_W'(f_tmp);
      w_spec_cnt_nx = CNT_W'(s_tmp);
    end
  end

  // state registers and entry writes; reset seeds the list with the non-architectural indices
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) r_entries[i] <= ADDR_WIDTH'(ARCH_COUNT + i);
      r_spec_head  <= '0;
      r_cmt_head   <= '0;
      r_tail       <= '0;
      r_free_count <= CNT_W'(FL_DEPTH);
      r_spec_cnt   <= '0;
    end else if (bus.clk_en) begin
      for (int q = 0; q < RECLAIM_PORTS; q++)
        if (w_push_en[q]) r_entries[w_push_ptr[q]] <= bus.reclaim_addr[q];
      r_spec_head  <= w_spec_head_nx;
      r_cmt_head   <= w_cmt_head_nx;
      r_tail       <= w_tail_nx;
      r_free_count <= w_free_nx;
      r_spec_cnt   <= w_spec_cnt_nx;
    end
  end

`ifdef FREELIST_ERR_CHK_EN
  logic [PHYS_COUNT-1:0] w_in_list;
  logic                  w_err;
  logic                  r_fl_err;

  // in-list bitmap rebuilt from the live window spec_head .. tail
  always_comb begin
    w_in_list = '0;
    for (int i = 0; i < FL_DEPTH; i++)
      if (((i - int'(r_spec_head) + FL_DEPTH) % FL_DEPTH) < int'(r_free_count))
        w_in_list[r_entries[i]] = 1'b1;
  end

  // protocol violations: double free, overflow drop, freeing index 0, commit overrun
  always_comb begin
    w_err = 1'b0;
    if (bus.clk_en) begin
      if (w_drop) w_err = 1'b1;
      if (int'(bus.commit_cnt) > int'(r_spec_cnt)) w_err = 1'b1;
      for (int q = 0; q < RECLAIM_PORTS; q++) begin
        if (bus.reclaim_en[q]) begin
          if (bus.reclaim_addr[q] == '0) w_err = 1'b1;
          if (w_in_list[bus.reclaim_addr[q]]) w_err = 1'b1;
          for (int q2 = 0; q2 < q; q2++)
            if (bus.reclaim_en[q2] && (bus.reclaim_addr[q2] == bus.reclaim_addr[q])) w_err = 1'b1;
        end
      end
    end
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) r_fl_err <= 1'b0;
    else if (w_err)   r_fl_err <= 1'b1;
  end

  assign bus.fl_err = r_fl_err;
`endif
endmodule
